sobel_frame_sequencer: RTL and testbench

- Frame-level controller in front of, and behind, the 4-line-buffer 3x3 window controller in the Sobel pipeline.
- Sequences one frame per `start`: clears the window controller, then meters input pixels from the DMA read stream so the writer never overwrites a line buffer still being read.
- Forwards window outputs to the downstream stream and counts them, raising `m_last` and `done` on the final output pixel.

---
 rtl/sobel_frame_sequencer_if.sv | 25 ++
 rtl/sobel_frame_sequencer.sv | 157 +++++++++++++++
 tb/tb_sobel_frame_sequencer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_frame_sequencer_if.sv
// Stream and window-controller signals around the Sobel frame sequencer.
// master: the sequencer itself. slave: the DMA, window controller and downstream side.
interface sobel_frame_sequencer_if;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic       lb_rst;
    logic       lb_valid;
    logic [7:0] lb_data;
    logic       win_valid;
    logic       win_ready;
    logic       m_valid;
    logic       m_last;
    logic       m_ready;

    modport master (
        input  s_valid, s_data, win_valid, m_ready,
        output s_ready, lb_rst, lb_valid, lb_data, win_ready, m_valid, m_last
    );

    modport slave (
        output s_valid, s_data, win_valid, m_ready,
        input  s_ready, lb_rst, lb_valid, lb_data, win_ready, m_valid, m_last
    );
endinterface

// File: rtl/sobel_frame_sequencer.sv
// Frame-level sequencer around the 4-line-buffer 3x3 window controller.
// Clears the window controller, meters input pixels so the line-buffer writer
// never overruns the lines being read, and forwards/counts window outputs.
module sobel_frame_sequencer #(
    parameter int IMG_W      = 128,
    parameter int IMG_H      = 128,
    parameter int CLR_CYCLES = 4
) (
    input  logic Clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    output logic busy,
    output logic done,
    sobel_frame_sequencer_if.master bus
);
    localparam int IN_TOTAL  = IMG_W * IMG_H;
    localparam int OUT_TOTAL = IMG_W * (IMG_H - 2);
    localparam int CNT_W     = $clog2(IN_TOTAL + 1);
    localparam int LINE_W    = $clog2(IMG_H + 1);
    localparam int PIX_W     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int CLR_W     = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    localparam logic [CNT_W-1:0] IN_END   = CNT_W'(IN_TOTAL);
    localparam logic [CNT_W-1:0] IN_LAST  = CNT_W'(IN_TOTAL - 1);
    localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(OUT_TOTAL - 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(IMG_W - 1);
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

    state_t            state_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              lb_rst_reg;
    logic [CNT_W-1:0]  in_cnt_reg;
    logic [CNT_W-1:0]  out_cnt_reg;
    logic [LINE_W-1:0] in_line_reg;
    logic [LINE_W-1:0] out_line_reg;
    logic [PIX_W-1:0]  in_pix_reg;
    logic [PIX_W-1:0]  out_pix_reg;
    logic [CLR_W-1:0]  clr_cnt_reg;

    logic              streaming;
    logic              lag_ok;
    logic [LINE_W:0]   lag_limit;
    logic              in_xfer;
    logic              out_xfer;

    // Writer may be at most one line buffer ahead of the three being read.
    assign lag_limit = {1'b0, out_line_reg} + (LINE_W + 1)'(3);
    assign lag_ok    = ({1'b0, in_line_reg} <= lag_limit);
    assign streaming = (state_reg == RUN) || (state_reg == DRAIN);

    assign bus.s_ready   = (state_reg == RUN) && (in_cnt_reg < IN_END) && lag_ok;
    assign in_xfer       = bus.s_valid && bus.s_ready;
    assign bus.lb_valid  = in_xfer;
    // Data is held at zero between strobes so the bus is quiet in reset and idle.
    assign bus.lb_data   = in_xfer ? bus.s_data : 8'd0;

    assign bus.m_valid   = streaming && bus.win_valid;
    assign bus.win_ready = streaming && bus.m_ready;
    assign out_xfer      = bus.m_valid && bus.m_ready;
    assign bus.m_last    = bus.m_valid && (out_cnt_reg == OUT_LAST);

    assign bus.lb_rst    = lb_rst_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;

    // Frame FSM with its counters and registered control outputs.
    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            lb_rst_reg   <= 1'b1;
            in_cnt_reg   <= '0;
            out_cnt_reg  <= '0;
            in_line_reg  <= '0;
            out_line_reg <= '0;
            in_pix_reg   <= '0;
            out_pix_reg  <= '0;
            clr_cnt_reg  <= '0;
        end else begin
            done_reg <= 1'b0;
            if (abort) begin
                state_reg  <= IDLE;
                busy_reg   <= 1'b0;
                lb_rst_reg <= 1'b1;
            end else begin
                case (state_reg)
                    IDLE: begin
                        lb_rst_reg <= 1'b1;
                        if (start) begin
                            state_reg    <= CLEAR;
                            busy_reg     <= 1'b1;
                            in_cnt_reg   <= '0;
                            out_cnt_reg  <= '0;
                            in_line_reg  <= '0;
                            out_line_reg <= '0;
                            in_pix_reg   <= '0;
                            out_pix_reg  <= '0;
                            clr_cnt_reg  <= '0;
                        end
                    end
                    CLEAR: begin
                        if (clr_cnt_reg == CLR_LAST) begin
                            state_reg  <= RUN;
                            lb_rst_reg <= 1'b0;
                        end else begin
                            clr_cnt_reg <= clr_cnt_reg + CLR_W'(1);
                        end
                    end
                    RUN, DRAIN: begin
                        if (in_xfer) begin
                            in_cnt_reg <= in_cnt_reg + CNT_W'(1);
                            if (in_pix_reg == PIX_LAST) begin
                                in_pix_reg  <= '0;
                                in_line_reg <= in_line_reg + LINE_W'(1);
                            end else begin
                                in_pix_reg <= in_pix_reg + PIX_W'(1);
                            end
                        end
                        if (out_xfer) begin
                            out_cnt_reg <= out_cnt_reg + CNT_W'(1);
                            if (out_pix_reg == PIX_LAST) begin
                                out_pix_reg  <= '0;
                                out_line_reg <= out_line_reg + LINE_W'(1);
                            end else begin
                                out_pix_reg <= out_pix_reg + PIX_W'(1);
                            end
                        end
                        // The final output ends the frame even if input is still pending.
                        if (out_xfer && bus.m_last) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else if ((state_reg == RUN) &&
                                     ((in_xfer && (in_cnt_reg == IN_LAST)) ||
                                      (in_cnt_reg == IN_END))) begin
                            state_reg <= DRAIN;
                        end
                    end
                    DONE: begin
                        state_reg  <= IDLE;
                        busy_reg   <= 1'b0;
                        lb_rst_reg <= 1'b1;
                    end
                    default: begin
                        state_reg  <= IDLE;
                        busy_reg   <= 1'b0;
                        lb_rst_reg <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// Directed testbench for the Sobel frame sequencer with a behavioural
// window controller: one output per input once two full lines are buffered.
module tb_sobel_frame_sequencer;
    localparam int IMG_W      = 128;
    localparam int IMG_H      = 128;
    localparam int CLR_CYCLES = 4;
    localparam int IN_TOTAL   = IMG_W * IMG_H;
    localparam int OUT_TOTAL  = IMG_W * (IMG_H - 2);

    logic Clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy;
    logic done;

    sobel_frame_sequencer_if bus();

    sobel_frame_sequencer #(
        .IMG_W      (IMG_W),
        .IMG_H      (IMG_H),
        .CLR_CYCLES (CLR_CYCLES)
    ) dut (
        .Clk   (Clk),
        .rst   (rst),
        .start (start),
        .abort (abort),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural window controller.
    int mdl_in  = 0;
    int mdl_out = 0;
    always @(posedge Clk or posedge rst) begin
        if (rst) begin
            mdl_in  <= 0;
            mdl_out <= 0;
        end else if (bus.lb_rst) begin
            mdl_in  <= 0;
            mdl_out <= 0;
        end else begin
            if (bus.lb_valid) mdl_in <= mdl_in + 1;
            if (bus.win_valid && bus.win_ready) mdl_out <= mdl_out + 1;
        end
    end
    assign bus.win_valid = ((mdl_in - 2 * IMG_W) > mdl_out);

    // Passive monitor, sampled mid-cycle.
    int   cyc = 0, n_in = 0, n_lb = 0, n_out = 0, n_last = 0, last_idx = 0;
    int   last_cyc = 0, n_done = 0, done_cyc = 0, busy_fall_cyc = 0, n_lbmis = 0;
    logic busy_q = 1'b0;
    always @(negedge Clk) begin
        cyc = cyc + 1;
        if (bus.s_valid && bus.s_ready) n_in = n_in + 1;
        if (bus.lb_valid) begin
            n_lb = n_lb + 1;
            if (bus.lb_data !== bus.s_data || bus.s_valid !== 1'b1) n_lbmis = n_lbmis + 1;
        end
        if (bus.lb_valid !== (bus.s_valid && bus.s_ready)) n_lbmis = n_lbmis + 1;
        if (bus.m_valid && bus.m_ready) begin
            n_out = n_out + 1;
            if (bus.m_last) begin
                n_last   = n_last + 1;
                last_idx = n_out;
                last_cyc = cyc;
            end
        end
        if (done) begin
            n_done   = n_done + 1;
            done_cyc = cyc;
        end
        if (busy_q && !busy) busy_fall_cyc = cyc;
        busy_q = busy;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge Clk);
        #1;
        bus.s_data = 8'($urandom);
    endtask

    // Runs one frame from start to done; optionally pokes start in RUN, DRAIN and DONE.
    task automatic drive_frame(input bit stall, input bit poke, output bit timed_out);
        int  n = 0;
        bit  drain_poked = 1'b0;
        int  b_in = n_in;
        timed_out   = 1'b1;
        bus.m_ready = 1'b1;
        bus.s_valid = 1'b1;
        start       = 1'b1;
        step();
        start = 1'b0;
        while (n < 40000) begin
            start = 1'b0;
            bus.s_valid = stall ? ($urandom_range(0, 99) >= 30) : 1'b1;
            if (poke && n == 1000) start = 1'b1;
            if (poke && !drain_poked && (n_in - b_in) == IN_TOTAL) begin
                start       = 1'b1;
                drain_poked = 1'b1;
            end
            if (done) begin
                if (poke) start = 1'b1;
                timed_out = 1'b0;
            end
            step();
            if (!timed_out) break;
            n++;
        end
        start       = 1'b0;
        bus.s_valid = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_reset();
        logic [15:0] obs;
        bus.s_valid = 1'b0; bus.s_data = 8'h00; bus.m_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        obs = {busy, done, bus.lb_rst, bus.s_ready, bus.lb_valid, bus.win_ready,
               bus.m_valid, bus.m_last, bus.lb_data};
        checks++;
        if (obs !== 16'h2000) begin
            failures++; $display("FAIL reset_outputs actual=%h expected=%h", obs, 16'h2000);
        end
        rst = 1'b0;
        step();
        start = 1'b1; step(); start = 1'b0;
        bus.s_valid = 1'b1; bus.m_ready = 1'b1;
        repeat (20) step();
        checks++;
        if ({busy, bus.s_ready} !== 2'b11) begin
            failures++; $display("FAIL run_before_reset actual=%b expected=11", {busy, bus.s_ready});
        end
        #2;
        bus.s_data = 8'hA5;
        rst = 1'b1;
        #1;
        obs = {busy, done, bus.lb_rst, bus.s_ready, bus.lb_valid, bus.win_ready,
               bus.m_valid, bus.m_last, bus.lb_data};
        checks++;
        if (obs !== 16'h2000) begin
            failures++; $display("FAIL async_reset_outputs actual=%h expected=%h", obs, 16'h2000);
        end
        #1;
        rst = 1'b0;
        bus.s_valid = 1'b0; bus.m_ready = 1'b0;
        step();
        checks++;
        if ({busy, bus.lb_rst} !== 2'b01) begin
            failures++; $display("FAIL idle_after_reset actual=%b expected=01", {busy, bus.lb_rst});
        end
        $display("test_reset done");
    endtask

    task automatic test_clear();
        int bad = 0;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < CLR_CYCLES; i++) begin
            if ({busy, bus.lb_rst, bus.s_ready} !== 3'b110) bad++;
            step();
        end
        checks++;
        if (bad !== 0) begin
            failures++; $display("FAIL clear_cycles bad_cycles=%0d expected=0", bad);
        end
        checks++;
        if ({bus.lb_rst, bus.s_ready} !== 2'b01) begin
            failures++; $display("FAIL run_entry actual=%b expected=01", {bus.lb_rst, bus.s_ready});
        end
        abort = 1'b1; step(); abort = 1'b0;
        $display("test_clear done");
    endtask

    task automatic test_streaming();
        bit to;
        int b_in = n_in, b_lb = n_lb, b_out = n_out, b_last = n_last, b_done = n_done, b_mis = n_lbmis;
        drive_frame(1'b0, 1'b0, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL stream_timeout actual=%0d expected=0", to); end
        checks++; if (n_in - b_in !== IN_TOTAL) begin failures++; $display("FAIL stream_in actual=%0d expected=%0d", n_in - b_in, IN_TOTAL); end
        checks++; if (n_lb - b_lb !== IN_TOTAL) begin failures++; $display("FAIL stream_lb actual=%0d expected=%0d", n_lb - b_lb, IN_TOTAL); end
        checks++; if (n_out - b_out !== OUT_TOTAL) begin failures++; $display("FAIL stream_out actual=%0d expected=%0d", n_out - b_out, OUT_TOTAL); end
        checks++; if (n_last - b_last !== 1) begin failures++; $display("FAIL stream_last_count actual=%0d expected=1", n_last - b_last); end
        checks++; if (last_idx - b_out !== OUT_TOTAL) begin failures++; $display("FAIL stream_last_index actual=%0d expected=%0d", last_idx - b_out, OUT_TOTAL); end
        checks++; if (n_done - b_done !== 1) begin failures++; $display("FAIL stream_done_count actual=%0d expected=1", n_done - b_done); end
        checks++; if (done_cyc !== last_cyc + 1) begin failures++; $display("FAIL stream_done_timing actual=%0d expected=%0d", done_cyc, last_cyc + 1); end
        checks++; if (busy_fall_cyc !== done_cyc + 1) begin failures++; $display("FAIL stream_busy_fall actual=%0d expected=%0d", busy_fall_cyc, done_cyc + 1); end
        checks++; if (n_lbmis - b_mis !== 0) begin failures++; $display("FAIL stream_lb_data actual=%0d expected=0", n_lbmis - b_mis); end
        $display("test_streaming frame in=%0d out=%0d", n_in - b_in, n_out - b_out);
    endtask

    task automatic test_backpressure();
        int b_in = n_in, b_out = n_out, b_done = n_done;
        bus.m_ready = 1'b0; bus.s_valid = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        repeat (700) step();
        checks++; if (n_in - b_in !== 512) begin failures++; $display("FAIL bp_in_stall actual=%0d expected=512", n_in - b_in); end
        checks++; if ({bus.s_ready, bus.m_valid, bus.win_ready} !== 3'b010) begin
            failures++; $display("FAIL bp_handshake actual=%b expected=010", {bus.s_ready, bus.m_valid, bus.win_ready});
        end
        bus.m_ready = 1'b1;
        repeat (128) step();
        bus.m_ready = 1'b0;
        repeat (200) step();
        checks++; if (n_out - b_out !== 128) begin failures++; $display("FAIL bp_out actual=%0d expected=128", n_out - b_out); end
        checks++; if (n_in - b_in !== 640) begin failures++; $display("FAIL bp_in_release actual=%0d expected=640", n_in - b_in); end
        checks++; if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_low actual=%b expected=0", bus.s_ready); end
        abort = 1'b1; step(); abort = 1'b0;
        bus.s_valid = 1'b0;
        repeat (3) step();
        checks++; if ({busy, n_done - b_done} !== {1'b0, 32'd0}) begin
            failures++; $display("FAIL bp_abort busy=%b dones=%0d expected busy=0 dones=0", busy, n_done - b_done);
        end
        $display("test_backpressure in=%0d out=%0d", n_in - b_in, n_out - b_out);
    endtask

    task automatic test_stalls();
        bit to;
        int b_in = n_in, b_lb = n_lb, b_out = n_out, b_done = n_done, b_mis = n_lbmis;
        drive_frame(1'b1, 1'b0, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL stall_timeout actual=%0d expected=0", to); end
        checks++; if (n_lb - b_lb !== IN_TOTAL) begin failures++; $display("FAIL stall_lb actual=%0d expected=%0d", n_lb - b_lb, IN_TOTAL); end
        checks++; if (n_in - b_in !== IN_TOTAL) begin failures++; $display("FAIL stall_in actual=%0d expected=%0d", n_in - b_in, IN_TOTAL); end
        checks++; if (n_out - b_out !== OUT_TOTAL) begin failures++; $display("FAIL stall_out actual=%0d expected=%0d", n_out - b_out, OUT_TOTAL); end
        checks++; if (n_lbmis - b_mis !== 0) begin failures++; $display("FAIL stall_lb_data actual=%0d expected=0", n_lbmis - b_mis); end
        checks++; if (n_done - b_done !== 1) begin failures++; $display("FAIL stall_done actual=%0d expected=1", n_done - b_done); end
        $display("test_stalls frame in=%0d out=%0d", n_in - b_in, n_out - b_out);
    endtask

    task automatic test_abort();
        int b_in = n_in, b_done = n_done, n = 0;
        bus.s_valid = 1'b1; bus.m_ready = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        while ((n_in - b_in) != 300 && n < 1000) begin
            step();
            n++;
        end
        checks++; if (n_in - b_in !== 300) begin failures++; $display("FAIL abort_reach actual=%0d expected=300", n_in - b_in); end
        abort = 1'b1; step(); abort = 1'b0;
        checks++; if ({busy, bus.lb_rst, bus.s_ready, bus.m_valid} !== 4'b0100) begin
            failures++; $display("FAIL abort_idle actual=%b expected=0100", {busy, bus.lb_rst, bus.s_ready, bus.m_valid});
        end
        start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_over_start actual=%b expected=0", busy); end
        repeat (20) step();
        bus.s_valid = 1'b0;
        checks++; if (n_done - b_done !== 0) begin failures++; $display("FAIL abort_no_done actual=%0d expected=0", n_done - b_done); end
        $display("test_abort in=%0d", n_in - b_in);
    endtask

    task automatic test_start_ignored();
        bit to;
        int b_in = n_in, b_out = n_out, b_last = n_last, b_done = n_done;
        drive_frame(1'b0, 1'b1, to);
        repeat (10) step();
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL ign_timeout actual=%0d expected=0", to); end
        checks++; if (n_in - b_in !== IN_TOTAL) begin failures++; $display("FAIL ign_in actual=%0d expected=%0d", n_in - b_in, IN_TOTAL); end
        checks++; if (n_out - b_out !== OUT_TOTAL) begin failures++; $display("FAIL ign_out actual=%0d expected=%0d", n_out - b_out, OUT_TOTAL); end
        checks++; if (n_last - b_last !== 1) begin failures++; $display("FAIL ign_last actual=%0d expected=1", n_last - b_last); end
        checks++; if (n_done - b_done !== 1) begin failures++; $display("FAIL ign_done actual=%0d expected=1", n_done - b_done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ign_restart actual=%b expected=0", busy); end
        $display("test_start_ignored frame in=%0d out=%0d", n_in - b_in, n_out - b_out);
    endtask

    initial begin
        test_reset();
        test_clear();
        test_streaming();
        test_backpressure();
        test_stalls();
        test_abort();
        test_start_ignored();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
